e_mdu: RTL

Multiply/divide unit for the E stage of the five-stage MIPS pipeline. Executes mult, multu, div, divu, mfhi, mflo, mthi and mtlo against private HI/LO registers, with fixed multi-cycle latency. For mfhi/mflo it drives a 32-bit result that the E-stage result mux places in the E/M register, where it becomes M_ALURe for M-stage forwarding. It also exports Start/Busy so the hazard unit can stall MDU-class instructions in D.

---
 rtl/e_mdu_pkg.sv | 29 ++
 rtl/e_mdu.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/e_mdu_pkg.sv
// Shared MDU definitions: op encodings and default latencies, also used by the
// D-stage decoder and the hazard unit.
package e_mdu_pkg;

  typedef enum logic [3:0] {
    MDU_NONE  = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MFHI  = 4'd5,
    MDU_MFLO  = 4'd6,
    MDU_MTHI  = 4'd7,
    MDU_MTLO  = 4'd8
  } mdu_op_e;

  localparam int MDU_MULT_CYCLES = 5;
  localparam int MDU_DIV_CYCLES  = 10;

  function automatic logic mdu_is_start(input logic [3:0] op);
    logic r;
    case (op)
      MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: r = 1'b1;
      default:                                r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: fixed-latency mult/div into private HI/LO,
// with move-to/move-from access and Start/Busy for the hazard unit.
module e_mdu
  import e_mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MDU_MULT_CYCLES,
  parameter int DIV_CYCLES  = MDU_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] E_RS,
  input  logic [31:0] E_RT,
  input  logic [3:0]  E_MDUOp,
  output logic        E_Start,
  output logic        E_Busy,
  output logic [31:0] E_MDUOut
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  logic [31:0]      hi_q, hi_d, lo_q, lo_d;
  logic [31:0]      pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [31:0] res_hi_s, res_lo_s;
  logic [63:0] prod_s_s, prod_u_s;
  logic [31:0] mag_a_s, mag_b_s, uq_s, ur_s, sq_s, sr_s;

  assign E_Start = mdu_is_start(E_MDUOp);
  assign E_Busy  = busy_q;

  // Result datapath; signed divide works on magnitudes so 0x80000000 / -1 wraps cleanly.
  always_comb begin
    prod_s_s = {{32{E_RS[31]}}, E_RS} * {{32{E_RT[31]}}, E_RT};
    prod_u_s = {32'd0, E_RS} * {32'd0, E_RT};
    mag_a_s  = 32'd0;
    mag_b_s  = 32'd0;
    uq_s     = 32'd0;
    ur_s     = 32'd0;
    sq_s     = 32'd0;
    sr_s     = 32'd0;
    res_hi_s = hi_q;
    res_lo_s = lo_q;
    if (E_MDUOp == MDU_DIV) begin
      mag_a_s = E_RS[31] ? (32'd0 - E_RS) : E_RS;
      mag_b_s = E_RT[31] ? (32'd0 - E_RT) : E_RT;
    end else begin
      mag_a_s = E_RS;
      mag_b_s = E_RT;
    end
    if (mag_b_s != 32'd0) begin
      uq_s = mag_a_s / mag_b_s;
      ur_s = mag_a_s % mag_b_s;
    end else begin
      uq_s = 32'd0;
      ur_s = 32'd0;
    end
    sq_s = (E_RS[31] ^ E_RT[31]) ? (32'd0 - uq_s) : uq_s;
    sr_s = E_RS[31] ? (32'd0 - ur_s) : ur_s;
    // A zero divisor leaves HI/LO as they are, so pending simply snapshots them.
    case (E_MDUOp)
      MDU_MULT:  {res_hi_s, res_lo_s} = prod_s_s;
      MDU_MULTU: {res_hi_s, res_lo_s} = prod_u_s;
      MDU_DIV: begin
        if (E_RT != 32'd0) begin
          res_hi_s = sr_s;
          res_lo_s = sq_s;
        end else begin
          res_hi_s = hi_q;
          res_lo_s = lo_q;
        end
      end
      MDU_DIVU: begin
        if (E_RT != 32'd0) begin
          res_hi_s = ur_s;
          res_lo_s = uq_s;
        end else begin
          res_hi_s = hi_q;
          res_lo_s = lo_q;
        end
      end
      default: begin
        res_hi_s = hi_q;
        res_lo_s = lo_q;
      end
    endcase
  end

  // Next-state: launch, count down, retire pending into HI/LO, or move-to.
  always_comb begin
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    busy_d    = busy_q;
    cnt_d     = cnt_q;
    if (busy_q) begin
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        hi_d   = pend_hi_q;
        lo_d   = pend_lo_q;
        busy_d = 1'b0;
      end else begin
        busy_d = 1'b1;
      end
    end else begin
      case (E_MDUOp)
        MDU_MULT, MDU_MULTU: begin
          pend_hi_d = res_hi_s;
          pend_lo_d = res_lo_s;
          cnt_d     = CNT_W'(MULT_CYCLES);
          busy_d    = 1'b1;
        end
        MDU_DIV, MDU_DIVU: begin
          pend_hi_d = res_hi_s;
          pend_lo_d = res_lo_s;
          cnt_d     = CNT_W'(DIV_CYCLES);
          busy_d    = 1'b1;
        end
        MDU_MTHI: hi_d = E_RS;
        MDU_MTLO: lo_d = E_RS;
        default: begin
          hi_d = hi_q;
          lo_d = lo_q;
        end
      endcase
    end
  end

  // State registers; reset discards any in-flight operation.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
      busy_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      busy_q    <= busy_d;
      cnt_q     <= cnt_d;
    end
  end

  // Move-from read port.
  always_comb begin
    case (E_MDUOp)
      MDU_MFHI: E_MDUOut = hi_q;
      MDU_MFLO: E_MDUOut = lo_q;
      default:  E_MDUOut = 32'd0;
    endcase
  end

endmodule
